// File: rtl/round_key_scheduler.sv
// DES round-key scheduler: walks C/D through the 16-round rotate schedule and
// presents one PC-2 subkey at a time under a valid/accept handshake.
module round_key_scheduler (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CHIP_SELECT_BAR,
  input  logic        LOAD,
  input  logic        DECRYPT,
  input  logic [28:1] C_IN,
  input  logic [28:1] D_IN,
  input  logic        KEY_ACCEPT,
  output logic [48:1] SUBKEY,
  output logic        KEY_VALID,
  output logic [4:1]  ROUND,
  output logic        BUSY,
  output logic        DONE,
  output logic [1:0]  dbg_state
);

  // Handshake: a key transfers on a rising edge where KEY_VALID = 1 and
  // KEY_ACCEPT = 1; while KEY_ACCEPT = 0 the presented key and ROUND hold.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PRESENT = 2'd2} state_t;

  localparam logic [5:0] PC2 [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
    6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
    6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
    6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
    6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  state_t      state_q, state_d;
  logic [28:1] c_q, c_d, d_q, d_d;
  logic        dec_q, dec_d;
  logic [3:0]  step_q, step_d;
  logic [48:1] subkey_q, subkey_d;
  logic [4:1]  round_q, round_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic [3:0]  step_idx;
  logic [1:0]  amt;
  logic [28:1] c_rot, d_rot;
  logic [56:1] cd_rot;
  logic [48:1] key_rot;

  // Left rotate moves bit i+1 into bit i; right rotate is the inverse.
  function automatic logic [28:1] rotl1(input logic [28:1] x);
    return {x[1], x[28:2]};
  endfunction

  function automatic logic [28:1] rotr1(input logic [28:1] x);
    return {x[27:1], x[28]};
  endfunction

  function automatic logic [28:1] rot(input logic [28:1] x, input logic right, input logic [1:0] n);
    logic [28:1] r;
    r = x;
    for (int k = 0; k < 2; k++) begin
      if (n > 2'(k)) r = right ? rotr1(r) : rotl1(r);
    end
    return r;
  endfunction

  always_comb begin
    step_idx = (state_q == SHIFT) ? step_q : step_q + 4'd1;
    if (dec_q && step_idx == 4'd0) begin
      amt = 2'd0;
    end else if (step_idx == 4'd0 || step_idx == 4'd1 || step_idx == 4'd8 || step_idx == 4'd15) begin
      amt = 2'd1;
    end else begin
      amt = 2'd2;
    end
    c_rot  = rot(c_q, dec_q, amt);
    d_rot  = rot(d_q, dec_q, amt);
    cd_rot = {d_rot, c_rot};
    key_rot = '0;
    for (int j = 0; j < 48; j++) begin
      key_rot[j+1] = cd_rot[PC2[j]];
    end
  end

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    dec_d    = dec_q;
    step_d   = step_q;
    subkey_d = subkey_q;
    round_d  = round_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    if (CHIP_SELECT_BAR) begin
      done_d = done_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (LOAD) begin
            c_d     = C_IN;
            d_d     = D_IN;
            dec_d   = DECRYPT;
            step_d  = 4'd0;
            state_d = SHIFT;
          end
        end
        SHIFT, PRESENT: begin
          if (state_q == SHIFT || (KEY_ACCEPT && step_q != 4'd15)) begin
            c_d      = c_rot;
            d_d      = d_rot;
            step_d   = step_idx;
            subkey_d = key_rot;
            round_d  = dec_q ? 4'd15 - step_idx : step_idx;
            valid_d  = 1'b1;
            state_d  = PRESENT;
          end else if (KEY_ACCEPT) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
            // Decrypt rotations total 27; one more right step restores C0/D0.
            if (dec_q) begin
              c_d = rotr1(c_q);
              d_d = rotr1(d_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      dec_q    <= 1'b0;
      step_q   <= '0;
      subkey_q <= '0;
      round_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      dec_q    <= dec_d;
      step_q   <= step_d;
      subkey_q <= subkey_d;
      round_q  <= round_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign SUBKEY    = (CHIP_SELECT_BAR && !RESET) ? {48{1'bz}} : subkey_q;
  assign KEY_VALID = valid_q & ~CHIP_SELECT_BAR;
  assign DONE      = done_q & ~CHIP_SELECT_BAR;
  assign ROUND     = round_q;
  assign BUSY      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: doc/round_key_scheduler.md
ROUND_KEY_SCHEDULER -- requirements
Module: round_key_scheduler

Interface
REQ-001 Parameters: none; PC-2 table, shift schedule and round count (16) SHALL be fixed per FIPS 46-3.
REQ-002 CLK  in  1  single clock; all state SHALL update on rising edge.
REQ-003 RESET  in  1  asynchronous, active-high reset.
REQ-004 CHIP_SELECT_BAR  in  1  active-low block enable.
REQ-005 LOAD  in  1  start request; samples C_IN, D_IN, DECRYPT.
REQ-006 DECRYPT  in  1  0 = emit K1..K16, 1 = emit K16..K1.
REQ-007 C_IN  in  [28:1]  C0 from PC-1 (bit 1 = FIPS bit 1).
REQ-008 D_IN  in  [28:1]  D0 from PC-1.
REQ-009 KEY_ACCEPT  in  1  consumer takes SUBKEY this cycle.
REQ-010 SUBKEY  out  [48:1]  current round key, bit 1 = FIPS bit 1.
REQ-011 KEY_VALID  out  1  SUBKEY valid.
REQ-012 ROUND  out  [4:1]  key index minus 1 of SUBKEY (K1 = 0, K16 = 15).
REQ-013 BUSY  out  1  sequence in progress.
REQ-014 DONE  out  1  one-cycle pulse after last key accepted.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, PRESENT; BUSY = 1 in SHIFT and PRESENT.
REQ-016 IDLE: edge with LOAD = 1 and CHIP_SELECT_BAR = 0 SHALL capture C_IN, D_IN, DECRYPT, clear round count, enter SHIFT; LOAD otherwise ignored.
REQ-017 Left rotate by 1: C'[i] = C[i+1] for i = 1..27, C'[28] = C[1]; right rotate is the inverse; D identical.
REQ-018 Encrypt round n (1..16): left rotate C and D by 1 for n = 1, 2, 9, 16, else by 2; present Kn.
REQ-019 Decrypt step n (1..16): right rotate by 0 for n = 1, by 1 for n = 2, 9, 16, else by 2; present K(17-n).
REQ-020 SUBKEY[j] SHALL equal CD[PC2[j]], CD[1..28] = C, CD[29..56] = D, PC2 = 14 17 11 24 1 5 3 28 15 6 21 10 23 19 12 4 26 8 16 7 27 20 13 2 41 52 31 37 47 55 30 40 51 45 33 48 44 49 39 56 34 53 46 42 50 36 29 32.
REQ-021 SHIFT edge: rotate C, D for step 1, register SUBKEY and ROUND, KEY_VALID <= 1, enter PRESENT; KEY_VALID first high 2 edges after LOAD sampled.
REQ-022 PRESENT: SUBKEY, ROUND, KEY_VALID SHALL hold stable while KEY_ACCEPT = 0 (unbounded stall).
REQ-023 PRESENT edge with KEY_ACCEPT = 1, step < 16: perform next step on same edge; throughput 1 key/cycle with KEY_ACCEPT tied high.
REQ-024 PRESENT edge with KEY_ACCEPT = 1, step = 16: KEY_VALID <= 0, DONE <= 1 for one cycle, enter IDLE; C, D then equal C0, D0.
REQ-025 LOAD during SHIFT/PRESENT SHALL be ignored; new LOAD accepted in the DONE cycle.
REQ-026 CHIP_SELECT_BAR = 1: all registers hold, KEY_ACCEPT and LOAD ignored, KEY_VALID forced 0, DONE forced 0, SUBKEY high-impedance; deassertion resumes exactly where stalled.

Reset
REQ-027 RESET = 1 SHALL immediately force IDLE, C = D = 0, SUBKEY = 0, ROUND = 0, KEY_VALID = 0, DONE = 0, BUSY = 0, regardless of CLK or CHIP_SELECT_BAR.
REQ-028 Reset mid-sequence SHALL abort; no DONE pulse; next LOAD after release starts a fresh sequence.

Verification
REQ-029 Encrypt: C_IN = F0CCAAF, D_IN = 556678F, DECRYPT = 0, KEY_ACCEPT = 1 -> 16 consecutive valid cycles; SUBKEY 1B02EFFC7072 (ROUND 0), 79AED9DBC9E5 (ROUND 1), ..., CB3D8B0E17F5 (ROUND 15); DONE pulse next cycle.
REQ-030 Decrypt, same C/D, DECRYPT = 1 -> first SUBKEY CB3D8B0E17F5 ROUND 15, last 1B02EFFC7072 ROUND 0; DONE pulse.
REQ-031 Backpressure: KEY_ACCEPT low 5 cycles at ROUND 2 -> SUBKEY, ROUND, KEY_VALID unchanged; sequence completes correctly.
REQ-032 CHIP_SELECT_BAR high 3 cycles at ROUND 7 -> SUBKEY Z, KEY_VALID 0; after release ROUND 7 key reappears unchanged.
REQ-033 LOAD with different C_IN at ROUND 4 -> ignored, output keys unchanged.
REQ-034 RESET pulse at ROUND 9 -> all outputs 0 asynchronously, no DONE; subsequent LOAD reproduces REQ-029 sequence.
